// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and counter sizing.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Bits needed for a counter with range_n distinct values (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take during reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking so sync_q takes the pre-edge meta_q; blocking would collapse the chain to one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, start-glitch rejection, valid/ready output.
// Define UART_RX_PARITY_EN to expect and check a parity bit after the data bits.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned TICK_W = cnt_width(OVERSAMPLE);
    localparam int unsigned BIT_W  = cnt_width(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic                 rxs;
    rx_state_t            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 armed_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 frame_done;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    logic perr_q;
    logic parity_err_q;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    // armed_q blocks start detection until the line has been seen high, so a break is delivered once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (rxs) armed_q <= 1'b1;
                    if (baud_tick && !rxs && armed_q) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_q     <= 1'b0;
`endif
                    end
                end
                START: if (baud_tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end
                DATA: if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        shift_q    <= {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        perr_q     <= rxs ^ (^shift_q) ^ ODD_BIT;
                        state_q    <= STOP;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end
`endif
                STOP: if (baud_tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        if (!rxs) ferr_q <= 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            armed_q   <= rxs;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame_done = baud_tick && (state_q == STOP) &&
                        (tick_cnt_q == TICK_LAST) && (bit_cnt_q == STOP_LAST);

    // A completed frame meeting an unaccepted word is dropped; the held word wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (frame_done) begin
                if (valid_q && !data_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    data_q       <= shift_q;
                    valid_q      <= 1'b1;
                    frame_err_q  <= ferr_q | ~rxs;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= perr_q;
`endif
                end
            end else if (valid_q && data_ready) begin
                valid_q      <= 1'b0;
                frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (8 data bits, OVERSAMPLE=16, 1 stop, even parity).
// Build with UART_RX_PARITY_EN defined to also cover the parity frames.
module tb_uart_rx_param;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       rxd;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_words   = 0;
    int   n_overrun = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rxd         (rxd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (OS) @(negedge clk);
    endtask

    // par_flip inverts the correct even parity bit; push queues the expected word.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                              input logic push);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_v;
        e.perr = par_flip & PAR_EN;
        if (push) sb_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_v);
        rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (overrun_err) n_overrun++;
        if (!reset && data_valid && data_ready) begin
            n_words++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got data_out=%0h expected no word", data_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("word_data", 32'(data_out), 32'(mon_e.data));
                check("word_frame_err", 32'(frame_err), 32'(mon_e.ferr));
                check("word_parity_err", 32'(parity_err), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words_before;
        int ov_before;
        exp_t e;

        reset      = 1'b1;
        baud_tick  = 1'b1;
        rxd        = 1'b1;
        data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", {29'd0, frame_err, parity_err, overrun_err}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Back to back: second start bit follows the first stop bit directly.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        words_before = n_words;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_rose", 32'(busy), 1);
        repeat (30) @(negedge clk);
        check("glitch_busy_fell", 32'(busy), 0);
        check("glitch_no_word", 32'(n_words), 32'(words_before));
        check("glitch_no_flags", {30'd0, frame_err, overrun_err}, 0);

        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Break: one all-zero frame with frame_err, then nothing until the line idles.
        e.data = 8'h00;
        e.ferr = 1'b1;
        e.perr = 1'b0;
        sb_q.push_back(e);
        words_before = n_words;
        rxd = 1'b0;
        repeat (13 * OS) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("break_once", 32'(n_words - words_before), 1);

        ov_before = n_overrun;
        @(posedge clk); #1 data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("ovr_data_held", 32'(data_out), 32'h11);
        check("ovr_valid_held", 32'(data_valid), 1);
        check("ovr_pulses", 32'(n_overrun - ov_before), 1);
        @(posedge clk); #1 data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("ovr_drained", 32'(data_valid), 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit is 1, so sending 0 must flag an error.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
`endif

        // Reset while three data bits into a frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(data_valid), 0);
        check("midrst_data_out", 32'(data_out), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        check("overrun_total", 32'(n_overrun), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
